// File: rtl/dest_tag_match_tracker.sv
// -----------------------------------------------------------------------------
// dest_tag_match_tracker
//
// Purpose:
//   Tracks the destination register indices of in-flight instructions in a
//   DEPTH-entry tag pipeline (entry 0 = youngest). Each cycle, NUM_SRC source
//   indices are compared against every valid entry. For each source the block
//   reports whether it hit, and which is the youngest matching stage. These
//   results drive hazard detection and forwarding select.
//
// Configuration macro:
//   DEST_TAG_ZERO_FILTER_EN - when defined, writes to register index 0 are
//   never captured as valid. As a result rs=0 never hits and never counts.
//
// Ports:
//   clk          in   clock; all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   i_stall      in   hold all entries this cycle (entering instr not captured)
//   i_flush      in   invalidate all entries; beats stall and the new entry
//   i_rd_valid   in   entering instruction writes a register
//   i_rd         in   [ADDR_W]          destination index of entering instr
//   i_rs         in   [NUM_SRC*ADDR_W]  source s at [s*ADDR_W +: ADDR_W]
//   o_hit        out  [NUM_SRC]         source s matches a valid entry
//   o_hit_stage  out  [NUM_SRC*STG_W]   youngest matching entry, 0 if no hit
//   o_valid_cnt  out  [CNT_W]           registered number of valid entries
// -----------------------------------------------------------------------------
module dest_tag_match_tracker #(
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2,
    parameter int STG_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic                      i_rd_valid,
    input  logic [ADDR_W-1:0]         i_rd,
    input  logic [NUM_SRC*ADDR_W-1:0] i_rs,
    output logic [NUM_SRC-1:0]        o_hit,
    output logic [NUM_SRC*STG_W-1:0]  o_hit_stage,
    output logic [CNT_W-1:0]          o_valid_cnt
);

    // Entry storage: one valid bit and one tag per stage.
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [ADDR_W-1:0] tag_q [DEPTH];
    logic [ADDR_W-1:0] tag_d [DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Valid bit presented to entry 0 on an advance.
    logic new_vld;

    always_comb begin
`ifdef DEST_TAG_ZERO_FILTER_EN
        // Register x0 is hard-wired, so a write to it is never a producer.
        new_vld = i_rd_valid & (i_rd != '0);
`else
        new_vld = i_rd_valid;
`endif
    end

    // Next-state: flush > stall > advance.
    always_comb begin
        vld_d = vld_q;
        cnt_d = cnt_q;
        for (int k = 0; k < DEPTH; k++) begin
            tag_d[k] = tag_q[k];
        end

        if (i_flush) begin
            // Tags hold; only the valid bits and the count clear.
            vld_d = '0;
            cnt_d = '0;
        end else if (!i_stall) begin
            vld_d[0] = new_vld;
            tag_d[0] = i_rd;
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[k] = vld_q[k-1];
                tag_d[k] = tag_q[k-1];
            end
            // Add the incoming valid bit and drop the valid bit of the oldest
            // entry, which leaves the pipeline. The count stays in 0..DEPTH,
            // so this sum cannot wrap.
            cnt_d = cnt_q + CNT_W'(new_vld) - CNT_W'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            for (int k = 0; k < DEPTH; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    // Compare: purely combinational on the registered entries and live i_rs.
    logic [DEPTH-1:0] match [NUM_SRC];

    always_comb begin
        o_hit       = '0;
        o_hit_stage = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            match[s] = '0;
            for (int k = 0; k < DEPTH; k++) begin
                // Bitwise XNOR, then an AND reduction across the index.
                match[s][k] = vld_q[k] & (&(~(tag_q[k] ^ i_rs[s*ADDR_W +: ADDR_W])));
            end
            o_hit[s] = |match[s];
            // Scan from the oldest entry to the youngest, so that the youngest
            // matching producer is the last one written.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (match[s][k]) begin
                    o_hit_stage[s*STG_W +: STG_W] = STG_W'(k);
                end
            end
        end
    end

    assign o_valid_cnt = cnt_q;

endmodule

// File: tb/tb_dest_tag_match_tracker.sv
module tb_dest_tag_match_tracker;

    localparam int ADDR_W  = 5;
    localparam int DEPTH   = 3;
    localparam int NUM_SRC = 2;
    localparam int STG_W   = 2;
    localparam int CNT_W   = 2;

    logic                      clk;
    logic                      rst_n;
    logic                      i_stall;
    logic                      i_flush;
    logic                      i_rd_valid;
    logic [ADDR_W-1:0]         i_rd;
    logic [NUM_SRC*ADDR_W-1:0] i_rs;
    logic [NUM_SRC-1:0]        o_hit;
    logic [NUM_SRC*STG_W-1:0]  o_hit_stage;
    logic [CNT_W-1:0]          o_valid_cnt;

    int errors = 0;
    int checks = 0;

    dest_tag_match_tracker #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .NUM_SRC (NUM_SRC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_stall     (i_stall),
        .i_flush     (i_flush),
        .i_rd_valid  (i_rd_valid),
        .i_rd        (i_rd),
        .i_rs        (i_rs),
        .o_hit       (o_hit),
        .o_hit_stage (o_hit_stage),
        .o_valid_cnt (o_valid_cnt)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic advance(input logic v, input logic [ADDR_W-1:0] rd);
        i_rd_valid = v;
        i_rd       = rd;
        step();
        i_rd_valid = 1'b0;
        i_rd       = '0;
    endtask

    task automatic flush_all();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
    endtask

    // Scenario tasks
    task automatic test_reset();
        rst_n      = 1'b0;
        i_stall    = 1'b0;
        i_flush    = 1'b0;
        i_rd_valid = 1'b0;
        i_rd       = '0;
        i_rs       = {5'd3, 5'd7};
        #12;
        checks++;
        if (o_hit !== 2'b00 || o_hit_stage !== 4'd0 || o_valid_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_hold: hit=%b stage=%h cnt=%0d, expected hit=00 stage=0 cnt=0",
                     o_hit, o_hit_stage, o_valid_cnt);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (o_hit !== 2'b00 || o_hit_stage !== 4'd0 || o_valid_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_release: hit=%b stage=%h cnt=%0d, expected hit=00 stage=0 cnt=0",
                     o_hit, o_hit_stage, o_valid_cnt);
        end
    endtask

    task automatic test_forward_stages();
        flush_all();
        advance(1'b1, 5'd7);
        advance(1'b1, 5'd3);
        advance(1'b0, 5'd0);
        i_rs = {5'd3, 5'd7};
        #1;
        // entries: [0]=bubble, [1]=3, [2]=7
        checks++;
        if (o_hit !== 2'b11) begin
            errors++;
            $display("FAIL fwd_hit: got %b expected 11", o_hit);
        end
        checks++;
        if (o_hit_stage !== {2'd1, 2'd2}) begin
            errors++;
            $display("FAIL fwd_stage: got %b expected 0110", o_hit_stage);
        end
        checks++;
        if (o_valid_cnt !== 2'd2) begin
            errors++;
            $display("FAIL fwd_cnt: got %0d expected 2", o_valid_cnt);
        end
    endtask

    task automatic test_count_drain();
        logic [CNT_W-1:0] exp_cnt [3];
        exp_cnt[0] = 2'd2;
        exp_cnt[1] = 2'd1;
        exp_cnt[2] = 2'd0;
        flush_all();
        advance(1'b1, 5'd9);
        advance(1'b1, 5'd9);
        advance(1'b1, 5'd9);
        i_rs = {5'd0, 5'd9};
        #1;
        checks++;
        if (o_hit !== 2'b01 || o_hit_stage[1:0] !== 2'd0 || o_valid_cnt !== 2'd3) begin
            errors++;
            $display("FAIL full_nine: hit=%b stage0=%0d cnt=%0d, expected hit=01 stage0=0 cnt=3",
                     o_hit, o_hit_stage[1:0], o_valid_cnt);
        end
        // Fourth cycle presents a bubble; the count is still 3 during it.
        i_rd_valid = 1'b0;
        #1;
        checks++;
        if (o_valid_cnt !== 2'd3) begin
            errors++;
            $display("FAIL drain_start: got %0d expected 3", o_valid_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            advance(1'b0, 5'd0);
            checks++;
            if (o_valid_cnt !== exp_cnt[i]) begin
                errors++;
                $display("FAIL drain_%0d: got %0d expected %0d", i, o_valid_cnt, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_full_steady();
        flush_all();
        for (int i = 0; i < 5; i++) begin
            advance(1'b1, 5'(10 + i));
        end
        // entries: [0]=14, [1]=13, [2]=12
        i_rs = {5'd12, 5'd14};
        #1;
        checks++;
        if (o_valid_cnt !== 2'd3 || o_hit !== 2'b11 || o_hit_stage !== {2'd2, 2'd0}) begin
            errors++;
            $display("FAIL full_steady: cnt=%0d hit=%b stage=%b, expected cnt=3 hit=11 stage=1000",
                     o_valid_cnt, o_hit, o_hit_stage);
        end
    endtask

    task automatic test_stall();
        flush_all();
        advance(1'b1, 5'd4);
        advance(1'b1, 5'd5);
        advance(1'b1, 5'd6);
        // entries: [0]=6, [1]=5, [2]=4
        i_stall    = 1'b1;
        i_rd_valid = 1'b1;
        i_rd       = 5'd8;
        step();
        step();
        i_rs = {5'd4, 5'd8};
        #1;
        checks++;
        if (o_hit !== 2'b10 || o_hit_stage[3:2] !== 2'd2 || o_valid_cnt !== 2'd3) begin
            errors++;
            $display("FAIL stall_hold: hit=%b stage1=%0d cnt=%0d, expected hit=10 stage1=2 cnt=3",
                     o_hit, o_hit_stage[3:2], o_valid_cnt);
        end
        // The compare follows i_rs in the same cycle while stalled.
        i_rs = {5'd6, 5'd5};
        #1;
        checks++;
        if (o_hit !== 2'b11 || o_hit_stage !== {2'd0, 2'd1}) begin
            errors++;
            $display("FAIL stall_rs_change: hit=%b stage=%b, expected hit=11 stage=0001",
                     o_hit, o_hit_stage);
        end
        i_stall    = 1'b0;
        i_rd_valid = 1'b0;
        i_rd       = '0;
    endtask

    task automatic test_flush_priority();
        // Entries are full from the previous scenario.
        i_flush    = 1'b1;
        i_stall    = 1'b1;
        i_rd_valid = 1'b1;
        i_rd       = 5'd2;
        step();
        i_flush    = 1'b0;
        i_stall    = 1'b0;
        i_rd_valid = 1'b0;
        i_rd       = '0;
        i_rs       = {5'd6, 5'd2};
        #1;
        checks++;
        if (o_valid_cnt !== 2'd0 || o_hit !== 2'b00) begin
            errors++;
            $display("FAIL flush_priority: cnt=%0d hit=%b, expected cnt=0 hit=00", o_valid_cnt, o_hit);
        end
    endtask

    task automatic test_duplicate_tags();
        flush_all();
        advance(1'b1, 5'd5);
        advance(1'b0, 5'd0);
        advance(1'b1, 5'd5);
        // entries: [0]=5, [1]=bubble, [2]=5
        i_rs = {5'd1, 5'd5};
        #1;
        checks++;
        if (o_hit !== 2'b01 || o_hit_stage[1:0] !== 2'd0 || o_valid_cnt !== 2'd2) begin
            errors++;
            $display("FAIL dup_youngest: hit=%b stage0=%0d cnt=%0d, expected hit=01 stage0=0 cnt=2",
                     o_hit, o_hit_stage[1:0], o_valid_cnt);
        end
        advance(1'b0, 5'd0);
        // entries: [0]=bubble, [1]=5, [2]=bubble
        checks++;
        if (o_hit !== 2'b01 || o_hit_stage[1:0] !== 2'd1 || o_valid_cnt !== 2'd1) begin
            errors++;
            $display("FAIL dup_shift: hit=%b stage0=%0d cnt=%0d, expected hit=01 stage0=1 cnt=1",
                     o_hit, o_hit_stage[1:0], o_valid_cnt);
        end
    endtask

    task automatic test_zero_index();
        flush_all();
        advance(1'b1, 5'd0);
        i_rs = {5'd9, 5'd0};
        #1;
`ifdef DEST_TAG_ZERO_FILTER_EN
        checks++;
        if (o_hit[0] !== 1'b0 || o_valid_cnt !== 2'd0) begin
            errors++;
            $display("FAIL zero_filtered: hit0=%b cnt=%0d, expected hit0=0 cnt=0", o_hit[0], o_valid_cnt);
        end
`else
        checks++;
        if (o_hit[0] !== 1'b1 || o_hit_stage[1:0] !== 2'd0 || o_valid_cnt !== 2'd1) begin
            errors++;
            $display("FAIL zero_tracked: hit0=%b stage0=%0d cnt=%0d, expected hit0=1 stage0=0 cnt=1",
                     o_hit[0], o_hit_stage[1:0], o_valid_cnt);
        end
`endif
    endtask

    task automatic test_flush_at_reset_release();
        flush_all();
        advance(1'b1, 5'd1);
        advance(1'b1, 5'd2);
        advance(1'b1, 5'd3);
        rst_n   = 1'b0;
        i_flush = 1'b1;
        #2;
        rst_n = 1'b1;
        step();
        i_flush = 1'b0;
        i_rs    = {5'd3, 5'd1};
        #1;
        checks++;
        if (o_valid_cnt !== 2'd0 || o_hit !== 2'b00) begin
            errors++;
            $display("FAIL flush_reset_release: cnt=%0d hit=%b, expected cnt=0 hit=00", o_valid_cnt, o_hit);
        end
    endtask

    task automatic test_async_reset_mid();
        advance(1'b1, 5'd11);
        advance(1'b1, 5'd12);
        i_rs = {5'd12, 5'd11};
        #1;
        checks++;
        if (o_valid_cnt !== 2'd2 || o_hit !== 2'b11) begin
            errors++;
            $display("FAIL pre_async: cnt=%0d hit=%b, expected cnt=2 hit=11", o_valid_cnt, o_hit);
        end
        #2;
        rst_n = 1'b0;
        #1;
        // No clock edge has occurred since reset was asserted.
        checks++;
        if (o_valid_cnt !== 2'd0 || o_hit !== 2'b00 || o_hit_stage !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d hit=%b stage=%b, expected cnt=0 hit=00 stage=0000",
                     o_valid_cnt, o_hit, o_hit_stage);
        end
        #1;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_forward_stages();
        test_count_drain();
        test_full_steady();
        test_stall();
        test_flush_priority();
        test_duplicate_tags();
        test_zero_index();
        test_flush_at_reset_release();
        test_async_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dest_tag_match_tracker.md
Name: dest_tag_match_tracker

Overview:
- Parametrised successor to the single-pair register-index equality compare: tracks destination register indices of in-flight instructions in a DEPTH-entry tag pipeline.
- Compares NUM_SRC source indices against every valid entry each cycle.
- Reports a hit and the youngest matching stage per source, for hazard detection and forwarding select in the 5-stage pipeline.

Parameters:
- ADDR_W, 5, register index width in bits.
- DEPTH, 3, number of tracked stages (entry 0 = youngest); legal range 1..8.
- NUM_SRC, 2, number of source indices compared in parallel; legal range 1..4.
- Derived: STG_W = (DEPTH>1) ? $clog2(DEPTH) : 1.
- Derived: CNT_W = $clog2(DEPTH+1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_stall  input  1  hold all entries this cycle.
- i_flush  input  1  invalidate all entries this cycle.
- i_rd_valid  input  1  the instruction entering the tracker writes a register.
- i_rd  input  ADDR_W  destination index of the entering instruction.
- i_rs  input  NUM_SRC*ADDR_W  source indices; source s occupies bits [s*ADDR_W +: ADDR_W].
- o_hit  output  NUM_SRC  source s matches at least one valid entry.
- o_hit_stage  output  NUM_SRC*STG_W  index of the youngest matching entry per source; 0 when there is no hit.
- o_valid_cnt  output  CNT_W  number of valid entries.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- State: DEPTH entries, each holding {vld, tag[ADDR_W-1:0]}.
- Reset value: all vld=0, all tag=0. Therefore o_hit=0, o_hit_stage=0, o_valid_cnt=0 while rst_n=0 and in the first cycle after release.
- Update priority, per rising edge:
  - i_flush=1: all vld <= 0, tags hold. Flush beats stall and beats any new entry.
  - else i_stall=1: all entries hold. i_rd_valid and i_rd are ignored; that instruction is not captured.
  - else (advance):
    - entry0 <= {i_rd_valid, i_rd}.
    - entry k <= entry k-1 for k=1..DEPTH-1.
    - The oldest entry drops off.
    - An i_rd_valid=0 cycle inserts a bubble (vld=0).
- Compare (combinational on registered entries and current i_rs; zero-latency from i_rs):
  - match[s][k] = vld[k] & (tag[k] == rs_s).
  - Equality is a per-bit XNOR followed by an AND reduction over ADDR_W bits.
  - o_hit[s] = OR over k of match[s][k].
  - o_hit_stage[s] = lowest k with match[s][k]=1, i.e. the youngest producer wins.
- Counter: o_valid_cnt is a registered count, updated with the entries.
  - Flush: next value = 0.
  - Stall: holds.
  - Advance: next value = current + new vld − vld of the outgoing oldest entry.
  - Never exceeds DEPTH; never underflows.
- Boundaries:
  - DEPTH=1: o_hit_stage is always 0.
  - All entries valid and advancing with i_rd_valid=1: count stays at DEPTH.
  - Flush asserted simultaneously with reset release: state stays cleared.
  - Reset asserted mid-operation: state clears immediately, without waiting for a clock edge.
  - Identical tags in several entries: the youngest stage is reported.
  - i_rs changes while stalled: the compare reflects the new i_rs in the same cycle.

Optional Feature:
- Macro: DEST_TAG_ZERO_FILTER_EN.
- Defined: on advance, entry0.vld <= i_rd_valid & (i_rd != 0). Writes to register x0 are never tracked, so rs=0 never hits and never counts.
- Not defined: i_rd=0 with i_rd_valid=1 is tracked and counted like any other index, and rs=0 can hit.
- Compare logic, counter and all other behaviour are identical in both builds.

Test Plan:
- Reset then idle, with i_rs={5'd3,5'd7} → o_hit=2'b00, o_hit_stage=0, o_valid_cnt=0.
- Advance rd=7 valid, then rd=3 valid, then a bubble; i_rs={5'd3,5'd7} → source0 (rs=7) hits stage 2, source1 (rs=3) hits stage 1, o_hit=2'b11, o_valid_cnt=2.
- rd=9 for three consecutive valid advances, rs0=9 → o_hit_stage=0, o_valid_cnt=3. A fourth cycle with i_rd_valid=0 → o_valid_cnt=3; it then falls to 2, 1 and 0 over the next bubble cycles.
- Fill with rd=4,5,6, then hold i_stall=1 for 2 cycles with i_rd=8 valid → entries unchanged, rs=8 gives no hit, o_valid_cnt=3.
- i_flush=1 together with i_stall=1 and valid i_rd=2 → next cycle o_valid_cnt=0 and rs=2 gives no hit.
- rd=0 valid advanced, then rs=0:
  - with DEST_TAG_ZERO_FILTER_EN → o_hit[0]=0, o_valid_cnt=0.
  - without it → o_hit[0]=1, stage 0, o_valid_cnt=1.
